// File: rtl/edge_detect_multi.sv
// edge_detect_multi
// Multi-channel edge detector for asynchronous pins. Each channel has a
// synchroniser, a glitch filter with a hold time of FILTER_CYCLES, a
// registered edge detector, a runtime edge-mode qualifier and a
// software-clearable sticky event flag.
module edge_detect_multi #(
  parameter int   CH_NUM        = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic IDLE_LEVEL    = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     sig_in,
  input  logic [2*CH_NUM-1:0]   edge_mode,
  input  logic [CH_NUM-1:0]     evt_clr,
  output logic [CH_NUM-1:0]     level_out,
  output logic [CH_NUM-1:0]     rise_pulse,
  output logic [CH_NUM-1:0]     fall_pulse,
  output logic [CH_NUM-1:0]     edge_pulse,
  output logic [CH_NUM-1:0]     evt_sticky,
  output logic                  any_evt
);

  localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   sync_lvl;
    logic                   accept;
    logic                   rise_d;
    logic                   fall_d;
    logic                   edge_d;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   edge_q;
    logic                   sticky_q;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Synchroniser shift register; stages start at the idle level so that
    // reset release never looks like an edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift.
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
    end

    // Filter decision: count consecutive cycles the synchronised level
    // differs from the accepted level; accept on the last hold cycle.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
      cnt_d  = '0;
      accept = 1'b0;
      if (sync_lvl != level_q) begin
        if (cnt_q == CNT_LAST) accept = 1'b1;
        else                   cnt_d  = cnt_q + 1'b1;
      end
    end

    // Edge classification for the level being accepted this cycle; the
    // mode is the value present on the update edge.
    always_comb begin
      rise_d = accept &  sync_lvl;
      fall_d = accept & ~sync_lvl;
      edge_d = (rise_d & edge_mode[2*i]) | (fall_d & edge_mode[2*i+1]);
    end

    // Filter counter, accepted level and edge pulses, updated together so
    // a pulse is high exactly in the cycle the new level first appears.
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        level_q <= IDLE_LEVEL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        edge_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        if (accept) level_q <= sync_lvl;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        edge_q  <= edge_d;
      end
    end

    // Sticky event flag: a qualified edge sets it, clear only drops it
    // when no set is present in the same cycle.
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) sticky_q <= 1'b0;
      else     sticky_q <= edge_q | (sticky_q & ~evt_clr[i]);
    end

    assign level_out[i]  = level_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign edge_pulse[i] = edge_q;
    assign evt_sticky[i] = sticky_q;
  end

  // Summary event flag, purely from registered sticky bits.
  assign any_evt = |evt_sticky;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed testbench for edge_detect_multi with default parameters.
// Inputs change 1 time unit after a rising edge and outputs are sampled
// at the same point, so a "cycle k" below means "just after posedge Ek".
module tb_edge_detect_multi;

  localparam int CH = 4;

  logic            sys_clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   sig_in;
  logic [2*CH-1:0] edge_mode;
  logic [CH-1:0]   evt_clr;
  logic [CH-1:0]   level_out;
  logic [CH-1:0]   rise_pulse;
  logic [CH-1:0]   fall_pulse;
  logic [CH-1:0]   edge_pulse;
  logic [CH-1:0]   evt_sticky;
  logic            any_evt;

  int tests_run = 0;
  int fails     = 0;
  int rise_cnt [CH];
  int fall_cnt [CH];
  int edge_cnt [CH];

  edge_detect_multi dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .edge_mode  (edge_mode),
    .evt_clr    (evt_clr),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_pulse (edge_pulse),
    .evt_sticky (evt_sticky),
    .any_evt    (any_evt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
      edge_cnt[c] = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      for (int c = 0; c < CH; c++) begin
        rise_cnt[c] += int'(rise_pulse[c]);
        fall_cnt[c] += int'(fall_pulse[c]);
        edge_cnt[c] += int'(edge_pulse[c]);
      end
    end
  endtask

  task automatic test_reset();
    int any_pulse;
    rst = 1'b1; sig_in = 4'hF; edge_mode = '0; evt_clr = '0;
    repeat (3) step();
    tests_run++;
    if ({level_out, rise_pulse, fall_pulse, edge_pulse, evt_sticky} !== 20'hF0000) begin
      fails++;
      $display("FAIL reset_values: got lvl=%h r=%h f=%h e=%h s=%h, want lvl=f rest 0",
               level_out, rise_pulse, fall_pulse, edge_pulse, evt_sticky);
    end
    rst = 1'b0;
    clear_counts();
    run(50);
    any_pulse = 0;
    for (int c = 0; c < CH; c++) any_pulse += rise_cnt[c] + fall_cnt[c] + edge_cnt[c];
    tests_run++;
    if (any_pulse !== 0) begin
      fails++; $display("FAIL reset_idle_pulses: got %0d pulses, want 0", any_pulse);
    end
    tests_run++;
    if (level_out !== 4'hF || any_evt !== 1'b0 || evt_sticky !== 4'h0) begin
      fails++;
      $display("FAIL reset_idle_state: got lvl=%h any=%b s=%h, want f/0/0", level_out, any_evt, evt_sticky);
    end
  endtask

  task automatic test_uart_start();
    edge_mode[1:0] = 2'b10;
    clear_counts();
    sig_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      rise_cnt[0] += int'(rise_pulse[0]);
      tests_run++;
      if (fall_pulse[0] !== (k == 6) || edge_pulse[0] !== (k == 6)) begin
        fails++;
        $display("FAIL uart_pulse cycle %0d: got fall=%b edge=%b, want %b", k, fall_pulse[0], edge_pulse[0], k == 6);
      end
      tests_run++;
      if (level_out[0] !== (k < 6)) begin
        fails++; $display("FAIL uart_level cycle %0d: got %b, want %b", k, level_out[0], k < 6);
      end
      tests_run++;
      if (evt_sticky[0] !== (k >= 7) || any_evt !== (k >= 7)) begin
        fails++;
        $display("FAIL uart_sticky cycle %0d: got s=%b any=%b, want %b", k, evt_sticky[0], any_evt, k >= 7);
      end
    end
    run(12);
    tests_run++;
    if (rise_cnt[0] !== 0) begin
      fails++; $display("FAIL uart_no_rise: got %0d, want 0", rise_cnt[0]);
    end
    // Return to idle: rising edge is not qualified under mode 10.
    clear_counts();
    sig_in[0] = 1'b1;
    run(20);
    tests_run++;
    if (rise_cnt[0] !== 1 || edge_cnt[0] !== 0) begin
      fails++; $display("FAIL uart_idle_return: got rise=%0d edge=%0d, want 1/0", rise_cnt[0], edge_cnt[0]);
    end
    evt_clr[0] = 1'b1; step(); evt_clr[0] = 1'b0; step();
    tests_run++;
    if (evt_sticky[0] !== 1'b0 || any_evt !== 1'b0) begin
      fails++; $display("FAIL uart_clear: got s=%b any=%b, want 0/0", evt_sticky[0], any_evt);
    end
  endtask

  task automatic test_glitch(input int width, input int exp_pulses);
    int fall_at;
    int rise_at;
    fall_at = -1;
    rise_at = -1;
    clear_counts();
    sig_in[1] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (fall_pulse[1]) begin fall_cnt[1]++; fall_at = k; end
      if (rise_pulse[1]) begin rise_cnt[1]++; rise_at = k; end
      if (width == 3) begin
        tests_run++;
        if (level_out[1] !== 1'b1) begin
          fails++; $display("FAIL glitch_level cycle %0d: got %b, want 1", k, level_out[1]);
        end
      end
      if (k == width) sig_in[1] = 1'b1;
    end
    tests_run++;
    if (fall_cnt[1] !== exp_pulses || rise_cnt[1] !== exp_pulses) begin
      fails++;
      $display("FAIL glitch_w%0d_count: got fall=%0d rise=%0d, want %0d", width, fall_cnt[1], rise_cnt[1], exp_pulses);
    end
    if (exp_pulses == 1) begin
      tests_run++;
      if (fall_at !== 6 || rise_at !== 10) begin
        fails++; $display("FAIL glitch_timing: got fall@%0d rise@%0d, want 6/10", fall_at, rise_at);
      end
    end
  endtask

  task automatic test_mode_matrix();
    logic [1:0] mode;
    int exp_edges [4] = '{0, 1, 1, 2};
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      edge_mode[5:4] = mode;
      clear_counts();
      sig_in[2] = 1'b0;
      run(10);
      sig_in[2] = 1'b1;
      run(10);
      tests_run++;
      if (edge_cnt[2] !== exp_edges[m] || rise_cnt[2] !== 1 || fall_cnt[2] !== 1) begin
        fails++;
        $display("FAIL mode_%b: got edge=%0d rise=%0d fall=%0d, want %0d/1/1",
                 mode, edge_cnt[2], rise_cnt[2], fall_cnt[2], exp_edges[m]);
      end
    end
    // A mode change on a quiet line must not raise anything.
    evt_clr[2] = 1'b1; step(); evt_clr[2] = 1'b0;
    clear_counts();
    edge_mode[5:4] = 2'b00; run(3);
    edge_mode[5:4] = 2'b11; run(5);
    tests_run++;
    if (edge_cnt[2] !== 0 || evt_sticky[2] !== 1'b0) begin
      fails++; $display("FAIL mode_change_quiet: got edge=%0d s=%b, want 0/0", edge_cnt[2], evt_sticky[2]);
    end
  endtask

  task automatic test_sticky_priority();
    edge_mode[7:6] = 2'b11;
    evt_clr[3] = 1'b1;
    sig_in[3] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) begin
        tests_run++;
        if (edge_pulse[3] !== 1'b1) begin
          fails++; $display("FAIL sticky_edge: got %b, want 1", edge_pulse[3]);
        end
      end
    end
    tests_run++;
    if (evt_sticky[3] !== 1'b1) begin
      fails++; $display("FAIL sticky_set_wins: got %b, want 1", evt_sticky[3]);
    end
    evt_clr[3] = 1'b0;
    step();
    // Second qualified event on an already-set flag keeps it set.
    sig_in[3] = 1'b1;
    run(10);
    tests_run++;
    if (evt_sticky[3] !== 1'b1 || any_evt !== 1'b1) begin
      fails++; $display("FAIL sticky_hold: got s=%b any=%b, want 1/1", evt_sticky[3], any_evt);
    end
    evt_clr[3] = 1'b1; step(); evt_clr[3] = 1'b0;
    tests_run++;
    if (evt_sticky[3] !== 1'b0 || any_evt !== 1'b0) begin
      fails++; $display("FAIL sticky_clear: got s=%b any=%b, want 0/0", evt_sticky[3], any_evt);
    end
  endtask

  task automatic test_reset_mid_filter();
    edge_mode[1:0] = 2'b10;
    clear_counts();
    // Five low samples leave the filter one cycle short of acceptance.
    sig_in[0] = 1'b0;
    run(5);
    rst = 1'b1;
    #1;
    tests_run++;
    if (level_out[0] !== 1'b1 || fall_pulse[0] !== 1'b0) begin
      fails++; $display("FAIL midfilt_async: got lvl=%b fall=%b, want 1/0", level_out[0], fall_pulse[0]);
    end
    sig_in[0] = 1'b1;
    step(); step();
    rst = 1'b0;
    run(20);
    tests_run++;
    if (fall_cnt[0] !== 0 || level_out[0] !== 1'b1 || evt_sticky[0] !== 1'b0) begin
      fails++;
      $display("FAIL midfilt_after: got fall=%0d lvl=%b s=%b, want 0/1/0", fall_cnt[0], level_out[0], evt_sticky[0]);
    end
    // Full latency from scratch proves the count restarted at zero.
    sig_in[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      tests_run++;
      if (level_out[0] !== (k < 6)) begin
        fails++; $display("FAIL midfilt_restart cycle %0d: got %b, want %b", k, level_out[0], k < 6);
      end
    end
    sig_in[0] = 1'b1;
    run(10);
  endtask

  initial begin
    test_reset();
    test_uart_start();
    test_glitch(3, 0);
    test_glitch(4, 1);
    test_mode_matrix();
    test_sticky_priority();
    test_reset_mid_filter();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
